// File: rtl/fifo_reader_fwft.sv
// fifo_reader_fwft
// Turns a normal-mode (registered-output) FIFO read port into a
// first-word-fall-through valid/ready stream.
//
// A two-entry skid buffer absorbs the one-cycle read latency of the
// upstream FIFO. A read is only issued when the word it returns is
// guaranteed a slot, counting words already buffered (occ), the word
// still in flight (infl) and any word leaving this cycle (pop).
// That gives 1 word/cycle throughput with no overflow and no drops.
module fifo_reader_fwft #(
    parameter int DATA_W    = 16,
    parameter int BUF_DEPTH = 2     // only 2 is supported: pointers are 1 bit wide
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_r_req,
    input  logic [DATA_W-1:0] fifo_r_data,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       words_out
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              infl_reg;
    logic              rd_ptr_reg;
    logic              rd_ptr_next;
    logic              wr_ptr_reg;
    logic              wr_ptr_next;
    logic              out_valid_reg;
    logic [31:0]       words_out_reg;
    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];

    logic              pop;
    logic              wr_en;
    logic [1:0]        committed;

    // A pop is a valid/ready handshake; the returning read data is
    // always written, because it was only requested when a slot was free.
    assign pop   = out_valid_reg & out_ready;
    assign wr_en = infl_reg;

    // Slots spoken for after this cycle. pop implies occ >= 1, so this
    // cannot wrap below zero.
    assign committed  = occ_reg + {1'b0, infl_reg} - {1'b0, pop};
    assign fifo_r_req = ~rst & ~fifo_empty & (committed < DEPTH);

    assign out_valid = out_valid_reg;
    assign out_data  = buf_mem[rd_ptr_reg];
    assign words_out = words_out_reg;

    // Next occupancy and ring pointers; a simultaneous write and pop
    // leaves occ unchanged while both pointers advance.
    always_comb begin
        occ_next    = occ_reg + {1'b0, wr_en} - {1'b0, pop};
        rd_ptr_next = rd_ptr_reg ^ pop;
        wr_ptr_next = wr_ptr_reg ^ wr_en;
    end

    // Control state: occupancy, in-flight flag, pointers, valid, pop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg       <= 2'd0;
            infl_reg      <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            words_out_reg <= 32'd0;
        end else begin
            occ_reg       <= occ_next;
            infl_reg      <= fifo_r_req;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            out_valid_reg <= (occ_next != 2'd0);
            if (pop) begin
                words_out_reg <= words_out_reg + 32'd1;
            end
        end
    end

    // One storage register per buffer slot; the in-flight word lands at the tail.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            // Slot gi captures upstream read data when the tail points at it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_mem[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
                    buf_mem[gi] <= fifo_r_data;
                end
            end
        end
    endgenerate

endmodule
